// File: rtl/eco32_core_mpu_cfr_trc_pkg.sv
// Shared record layout and limits for the CFR flag-change trace buffer.
package eco32_core_mpu_cfr_trc_pkg;

    localparam int unsigned REC_W        = 32;
    localparam int unsigned REC_LOST_BIT = 31;
    localparam int unsigned REC_TH_BIT   = 30;
    localparam int unsigned REC_TS_MSB   = 29;
    localparam int unsigned REC_TS_LSB   = 7;
    localparam int unsigned REC_FLAGS_W  = 7;
    localparam int unsigned REC_TS_W     = REC_TS_MSB - REC_TS_LSB + 1;

    localparam logic [7:0] DROPS_MAX = 8'd255;

    function automatic logic [REC_W-1:0] rec_pack(
        input logic                   lost,
        input logic                   th,
        input logic [REC_TS_W-1:0]    ts,
        input logic [REC_FLAGS_W-1:0] flags
    );
        return {lost, th, ts, flags};
    endfunction

endpackage

// File: rtl/eco32_core_mpu_cfr_trc_fifo.sv
// First-word-fall-through FIFO; the caller guarantees wr_i is never raised when a write cannot land.
module eco32_core_mpu_cfr_trc_fifo #(
    parameter int unsigned DEPTH_LOG = 4,
    parameter int unsigned WIDTH     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_i,
    input  logic [WIDTH-1:0]   din_i,
    output logic               full_o,
    input  logic               rd_i,
    output logic [WIDTH-1:0]   dout_o,
    output logic               val_o,
    output logic [DEPTH_LOG:0] cnt_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG-1:0] rptr_q, rptr_d;
    logic [DEPTH_LOG:0]   cnt_q, cnt_d;
    logic                 do_rd;

    assign val_o  = (cnt_q != '0);
    assign full_o = (cnt_q == (DEPTH_LOG + 1)'(DEPTH));
    assign cnt_o  = cnt_q;
    assign do_rd  = rd_i & val_o;
    // Gate the head so an unwritten entry never leaks out while empty.
    assign dout_o = val_o ? mem_q[rptr_q] : '0;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (wr_i) begin
            wptr_d = wptr_q + DEPTH_LOG'(1);
        end
        if (do_rd) begin
            rptr_d = rptr_q + DEPTH_LOG'(1);
        end
        if (wr_i && !do_rd) begin
            cnt_d = cnt_q + (DEPTH_LOG + 1)'(1);
        end else if (!wr_i && do_rd) begin
            cnt_d = cnt_q - (DEPTH_LOG + 1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_i) begin
            mem_q[wptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/eco32_core_mpu_cfr_trc.sv
// CFR flag-change trace: timestamps and thread-tags each strobed flag update into a debug FIFO,
// tracking overflow with a lost marker, sticky flag and saturating drop counter.
module eco32_core_mpu_cfr_trc
    import eco32_core_mpu_cfr_trc_pkg::*;
#(
    parameter int unsigned     DEPTH_LOG  = 4,
    parameter int unsigned     TS_W       = 23,
    // Timestamp reset value (normally 0).
    parameter logic [TS_W-1:0] TS_RST_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_stb,
    input  logic [6:0]           i_flags,
    output logic                 o_val,
    output logic [31:0]          o_data,
    input  logic                 i_ack,
    output logic [DEPTH_LOG:0]   o_cnt,
    output logic                 o_ovf,
    output logic [7:0]           o_drops,
    input  logic                 i_clr
);

    logic [TS_W-1:0] ts_q, ts_d;
    logic            th_q, th_d;
    logic            lost_q, lost_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      drops_q, drops_d;

    logic            wr_req, pop, full, accept, drop;
    logic [REC_W-1:0] rec;

    assign wr_req = i_en & i_stb;
    assign pop    = o_val & i_ack;
    // A full FIFO still takes the write when the head leaves in the same cycle.
    assign accept = wr_req & (~full | pop);
    assign drop   = wr_req & ~accept;
    assign rec    = rec_pack(lost_q, th_q, ts_q, i_flags);

    always_comb begin
        ts_d    = ts_q + TS_W'(1);
        th_d    = ~th_q;
        lost_d  = lost_q;
        ovf_d   = ovf_q;
        drops_d = drops_q;
        if (accept) begin
            lost_d = 1'b0;
        end else if (drop) begin
            lost_d = 1'b1;
            ovf_d  = 1'b1;
            if (drops_q != DROPS_MAX) begin
                drops_d = drops_q + 8'd1;
            end
        end
        if (i_clr) begin
            ovf_d   = 1'b0;
            drops_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q    <= TS_RST_VAL;
            th_q    <= 1'b0;
            lost_q  <= 1'b0;
            ovf_q   <= 1'b0;
            drops_q <= '0;
        end else begin
            ts_q    <= ts_d;
            th_q    <= th_d;
            lost_q  <= lost_d;
            ovf_q   <= ovf_d;
            drops_q <= drops_d;
        end
    end

    eco32_core_mpu_cfr_trc_fifo #(
        .DEPTH_LOG (DEPTH_LOG),
        .WIDTH     (REC_W)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_i   (accept),
        .din_i  (rec),
        .full_o (full),
        .rd_i   (i_ack),
        .dout_o (o_data),
        .val_o  (o_val),
        .cnt_o  (o_cnt)
    );

    assign o_ovf   = ovf_q;
    assign o_drops = drops_q;

endmodule

// File: tb/tb_eco32_core_mpu_cfr_trc.sv
// Directed bench for the CFR trace buffer with a queue-based reference model checked every cycle.
module tb_eco32_core_mpu_cfr_trc;

    logic        clk, rst;
    logic        i_en, i_stb, i_ack, i_clr;
    logic [6:0]  i_flags;
    logic        o_val, o_ovf;
    logic [31:0] o_data;
    logic [4:0]  o_cnt;
    logic [7:0]  o_drops;

    // Second instance starts its timestamp near the top so the wrap is reachable.
    logic        w_stb, w_ack, w_val, w_ovf;
    logic [6:0]  w_flags;
    logic [31:0] w_data;
    logic [4:0]  w_cnt;
    logic [7:0]  w_drops;

    int n_tests = 0;
    int n_fail  = 0;

    eco32_core_mpu_cfr_trc dut (
        .clk(clk), .rst(rst), .i_en(i_en), .i_stb(i_stb), .i_flags(i_flags),
        .o_val(o_val), .o_data(o_data), .i_ack(i_ack), .o_cnt(o_cnt),
        .o_ovf(o_ovf), .o_drops(o_drops), .i_clr(i_clr)
    );

    eco32_core_mpu_cfr_trc #(.TS_RST_VAL(23'h7FFFFD)) u_wrap (
        .clk(clk), .rst(rst), .i_en(1'b1), .i_stb(w_stb), .i_flags(w_flags),
        .o_val(w_val), .o_data(w_data), .i_ack(w_ack), .o_cnt(w_cnt),
        .o_ovf(w_ovf), .o_drops(w_drops), .i_clr(1'b0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: records are pushed with the cycle count since reset release.
    logic [31:0] mq[$];
    int unsigned m_cyc   = 0;
    bit          m_lost  = 0;
    bit          m_ovf   = 0;
    int          m_drops = 0;

    initial begin
        bit          pop, req, th;
        logic [22:0] ts;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                m_cyc = 0; m_lost = 0; m_ovf = 0; m_drops = 0;
            end else begin
                pop = (mq.size() > 0) && i_ack;
                req = i_en && i_stb;
                ts  = 23'(m_cyc % 32'h0080_0000);
                th  = (m_cyc % 2) == 1;
                if (pop) void'(mq.pop_front());
                if (req) begin
                    if (mq.size() < 16) begin
                        mq.push_back({m_lost, th, ts, i_flags});
                        m_lost = 0;
                    end else begin
                        m_lost = 1;
                        m_ovf  = 1;
                        if (m_drops < 255) m_drops++;
                    end
                end
                if (i_clr) begin
                    m_ovf = 0;
                    m_drops = 0;
                end
                m_cyc++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("val", 32'(o_val), 32'(mq.size() != 0));
            chk("cnt", 32'(o_cnt), 32'(mq.size()));
            chk("ovf", 32'(o_ovf), 32'(m_ovf));
            chk("drops", 32'(o_drops), 32'(m_drops));
            if (mq.size() != 0) chk("data", o_data, mq[0]);
        end
    end

    task automatic cyc(input logic stb, input logic [6:0] fl, input logic ack);
        i_stb = stb; i_flags = fl; i_ack = ack;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] d;

    initial begin
        rst = 1'b1; i_en = 1'b1; i_stb = 0; i_flags = 0; i_ack = 0; i_clr = 0;
        w_stb = 0; w_flags = 0; w_ack = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_val", 32'(o_val), 32'd0);
        chk("rst_cnt", 32'(o_cnt), 32'd0);
        chk("rst_ovf", 32'(o_ovf), 32'd0);
        chk("rst_drops", 32'(o_drops), 32'd0);
        chk("rst_data", o_data, 32'd0);
        rst = 1'b0;

        // Idle up to timestamp 10 while the wrap instance records across its wrap.
        for (int k = 0; k < 10; k++) begin
            w_stb = (k == 2 || k == 3); w_flags = 7'(k); w_ack = (k == 5 || k == 6);
            if (k == 5) chk("wrap_rec0", w_data, {1'b0, 1'b0, 23'h7FFFFF, 7'h02});
            if (k == 6) chk("wrap_rec1", w_data, {1'b0, 1'b1, 23'h000000, 7'h03});
            cyc(0, 0, 0);
        end
        w_stb = 0; w_ack = 0;

        cyc(1, 7'h05, 0);
        chk("first_val", 32'(o_val), 32'd1);
        chk("first_rec", o_data, {1'b0, 1'b0, 23'd10, 7'h05});
        cyc(0, 0, 1);
        cyc(1, 7'h11, 0);
        cyc(1, 7'h22, 0);
        chk("pair_cnt2", 32'(o_cnt), 32'd2);
        chk("pair_rec0", o_data, {1'b0, 1'b0, 23'd12, 7'h11});
        cyc(0, 0, 1);
        chk("pair_cnt1", 32'(o_cnt), 32'd1);
        chk("pair_rec1", o_data, {1'b0, 1'b1, 23'd13, 7'h22});
        cyc(0, 0, 1);
        chk("pair_cnt0", 32'(o_cnt), 32'd0);

        for (int i = 0; i < 18; i++) cyc(1, 7'(i), 0);
        chk("ovf_cnt", 32'(o_cnt), 32'd16);
        chk("ovf_flag", 32'(o_ovf), 32'd1);
        chk("ovf_drops", 32'(o_drops), 32'd2);
        cyc(0, 0, 1);
        cyc(1, 7'h40, 0);
        cyc(1, 7'h41, 1);
        chk("fullpop_cnt", 32'(o_cnt), 32'd16);
        chk("fullpop_drops", 32'(o_drops), 32'd2);
        for (int i = 0; i < 16; i++) begin
            d = o_data;
            if (i == 14) chk("lost_set", 32'({d[31], d[6:0]}), 32'h0C0);
            if (i == 15) chk("lost_clr", 32'({d[31], d[6:0]}), 32'h041);
            cyc(0, 0, 1);
        end

        i_en = 1'b0;
        repeat (3) cyc(1, 7'h7F, 0);
        chk("en_cnt", 32'(o_cnt), 32'd0);
        chk("en_drops", 32'(o_drops), 32'd2);
        i_en = 1'b1;

        repeat (16) cyc(1, 7'h01, 0);
        repeat (260) cyc(1, 7'h02, 0);
        chk("sat_drops", 32'(o_drops), 32'd255);
        i_clr = 1'b1;
        cyc(1, 7'h03, 0);
        i_clr = 1'b0;
        chk("clr_drops", 32'(o_drops), 32'd0);
        chk("clr_ovf", 32'(o_ovf), 32'd0);
        repeat (16) cyc(0, 0, 1);

        for (int i = 0; i < 5; i++) cyc(1, 7'(i + 8), 0);
        chk("mid_cnt5", 32'(o_cnt), 32'd5);
        #2 rst = 1'b1;
        #1;
        chk("mid_val", 32'(o_val), 32'd0);
        chk("mid_cnt", 32'(o_cnt), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) cyc(0, 0, 0);
        cyc(1, 7'h33, 0);
        chk("post_rst_rec", o_data, {1'b0, 1'b1, 23'd3, 7'h33});
        cyc(0, 0, 1);
        cyc(0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
